thread_sched: RTL

//  Fine-grained multithread fetch scheduler. Each cycle it selects which hardware thread's PC
//  the fetch stage reads. Selection is round-robin, skipping threads that are stalled
//  (load-use or flush penalty) or halted. Drives tid_f into the per-thread PC bank and the

---
 rtl/mt_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/thread_sched.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mt_pkg.sv
// mt_pkg - shared multithreading definitions.
// Used by the fetch thread scheduler, the per-thread PC bank and the hazard unit.
// Contents: default thread count and derived thread-id width, default stall-counter width,
// default branch/jump flush penalty, and the per-thread scheduling state type.
package mt_pkg;

  localparam int NUM_THREADS_DEF   = 4;
  localparam int BITS_THREADS_DEF  = $clog2(NUM_THREADS_DEF);
  localparam int STALL_CNT_W_DEF   = 3;
  localparam int FLUSH_PENALTY_DEF = 2;

  // STALL is only ever held while the thread's countdown is nonzero.
  typedef enum logic [1:0] {
    TS_RUN   = 2'd0,
    TS_STALL = 2'd1,
    TS_HALT  = 2'd2
  } thread_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter - combinational rotate-priority pick.
// Searches req upward from last+1 (wrapping modulo N) and returns the first set bit.
// Ports:
//   req       in  N      request mask
//   last      in  IDX_W  index granted most recently (search starts just above it)
//   gnt_valid out 1      at least one request was set
//   gnt_idx   out IDX_W  winning index; equals last when nothing is requested
module rr_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] cand_s;

  // Walk the N candidates in rotation order; the first requester wins.
  // N is a power of two, so the IDX_W-bit add wraps naturally.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = last;
    cand_s    = last;
    for (int i = 1; i <= N; i++) begin
      cand_s = last + IDX_W'(i);
      if (!gnt_valid && req[cand_s]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_s;
      end else begin
        gnt_valid = gnt_valid;
      end
    end
  end

endmodule

// File: rtl/thread_sched.sv
// thread_sched - fine-grained multithread fetch scheduler.
// Each cycle picks, round-robin, the next thread that is running, not counting down a
// stall/flush penalty, and not being stalled/flushed/halted this very cycle.
// Ports:
//   clk, rst                   clock; asynchronous active-high reset
//   fetch_ready                fetch can take a new thread; 0 freezes tid_f/tid_valid_f/rotation
//   stall_req/tid/cycles       hazard-unit stall of one thread for stall_cycles (0 ignored)
//   pc_src_e, tid_e            taken branch/jump in E; blocks tid_e for FLUSH_PENALTY cycles
//   halt_req/tid               halt one thread
//   resume_req/tid             resume a halted thread
//   tid_f, tid_valid_f         selected thread and slot-valid (0 = bubble)
//   thread_run                 per-thread not-halted mask
//   all_halted                 every thread halted
module thread_sched
  import mt_pkg::*;
#(
  parameter int NUM_THREADS   = NUM_THREADS_DEF,
  parameter int STALL_CNT_W   = STALL_CNT_W_DEF,
  parameter int FLUSH_PENALTY = FLUSH_PENALTY_DEF,
  localparam int BITS_THREADS = $clog2(NUM_THREADS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_ready,
  input  logic                    stall_req,
  input  logic [BITS_THREADS-1:0] stall_tid,
  input  logic [STALL_CNT_W-1:0]  stall_cycles,
  input  logic                    pc_src_e,
  input  logic [BITS_THREADS-1:0] tid_e,
  input  logic                    halt_req,
  input  logic [BITS_THREADS-1:0] halt_tid,
  input  logic                    resume_req,
  input  logic [BITS_THREADS-1:0] resume_tid,
  output logic [BITS_THREADS-1:0] tid_f,
  output logic                    tid_valid_f,
  output logic [NUM_THREADS-1:0]  thread_run,
  output logic                    all_halted
);

  localparam logic [STALL_CNT_W-1:0]  CNT_ZERO  = {STALL_CNT_W{1'b0}};
  localparam logic [STALL_CNT_W-1:0]  CNT_ONE   = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_CNT_W-1:0]  FLUSH_CNT = STALL_CNT_W'(FLUSH_PENALTY);
  localparam logic [BITS_THREADS-1:0] LAST_RST  = BITS_THREADS'(NUM_THREADS - 1);

  function automatic logic [STALL_CNT_W-1:0] cnt_max(input logic [STALL_CNT_W-1:0] a,
                                                     input logic [STALL_CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [NUM_THREADS-1:0]  elig_s;
  logic [NUM_THREADS-1:0]  run_d;
  logic                    gnt_valid_s;
  logic [BITS_THREADS-1:0] gnt_idx_s;

  logic [BITS_THREADS-1:0] tid_q, tid_d, last_q, last_d;
  logic                    valid_q, valid_d;
  logic [NUM_THREADS-1:0]  run_q;
  logic                    all_halted_q, all_halted_d;

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
    localparam logic [BITS_THREADS-1:0] TID = BITS_THREADS'(t);

    thread_state_e          state_q, state_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d, load_s;
    logic                   halt_hit_s, resume_hit_s, stall_hit_s, flush_hit_s;

    assign halt_hit_s   = halt_req & (halt_tid == TID);
    assign resume_hit_s = resume_req & (resume_tid == TID);
    assign stall_hit_s  = stall_req & (stall_tid == TID) & (stall_cycles != CNT_ZERO);
    assign flush_hit_s  = pc_src_e & (tid_e == TID);
    // Stall and flush on the same thread: the longer penalty wins.
    assign load_s = cnt_max(stall_hit_s ? stall_cycles : CNT_ZERO,
                            flush_hit_s ? FLUSH_CNT : CNT_ZERO);

    // Same-cycle requests mask the thread so it is never granted as its stall/halt arrives.
    assign elig_s[t] = (state_q == TS_RUN) & (cnt_q == CNT_ZERO)
                     & ~halt_hit_s & ~stall_hit_s & ~flush_hit_s;
    assign run_d[t]  = (state_d != TS_HALT);

    // Next state: halt > resume > stall/flush load > countdown.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (halt_hit_s) begin
        state_d = TS_HALT;
      end else if (state_q == TS_HALT) begin
        if (resume_hit_s) begin
          state_d = TS_RUN;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = TS_HALT;
        end
      end else if (stall_hit_s || flush_hit_s) begin
        cnt_d   = cnt_max(cnt_q, load_s);
        state_d = (cnt_d != CNT_ZERO) ? TS_STALL : TS_RUN;
      end else if (cnt_q != CNT_ZERO) begin
        cnt_d   = cnt_q - CNT_ONE;
        state_d = (cnt_q == CNT_ONE) ? TS_RUN : TS_STALL;
      end else begin
        state_d = TS_RUN;
      end
    end

    // Per-thread state and countdown registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= TS_RUN;
        cnt_q   <= CNT_ZERO;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end
  end

  rr_arbiter #(.N(NUM_THREADS)) u_arb (
    .req       (elig_s),
    .last      (last_q),
    .gnt_valid (gnt_valid_s),
    .gnt_idx   (gnt_idx_s)
  );

  // Fetch slot update; fetch_ready low freezes the slot and the rotation point.
  always_comb begin
    tid_d   = tid_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (fetch_ready) begin
      if (gnt_valid_s) begin
        tid_d   = gnt_idx_s;
        valid_d = 1'b1;
        last_d  = gnt_idx_s;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Run mask and all-halted flag come from next-state so they carry no extra delay.
  assign all_halted_d = &(~run_d);

  // Output and rotation registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tid_q        <= {BITS_THREADS{1'b0}};
      valid_q      <= 1'b0;
      last_q       <= LAST_RST;
      run_q        <= {NUM_THREADS{1'b1}};
      all_halted_q <= 1'b0;
    end else begin
      tid_q        <= tid_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      run_q        <= run_d;
      all_halted_q <= all_halted_d;
    end
  end

  assign tid_f       = tid_q;
  assign tid_valid_f = valid_q;
  assign thread_run  = run_q;
  assign all_halted  = all_halted_q;

endmodule
